// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory, redirect and decode handshake signals of the fetch stage.
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_unit_queue.sv
// In-order {instr, pc} queue between instruction memory and decode.
module fetch_unit_queue
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  fetch_entry_t i_push_entry,
  input  logic         i_pop,
  output logic [CW-1:0] o_count,
  output fetch_entry_t o_head
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;

  assign w_pop = i_pop && (r_count != '0);

  // storage, pointers and occupancy; a flush only rewinds the pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= {NOP_INSTR, RESET_PC};
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // credit accounting upstream must never let a push land on a full queue
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !i_flush && (r_count == CW'(DEPTH)) && !w_pop));

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: fetch PC, credit-limited issue, response tracking, redirect flush.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic clk,
  input  logic rst_n,
  fetch_unit_if.master bus
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_drop;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_credit_used;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;
  logic          w_valid;
  logic          w_pop;
  logic          w_req;
  logic          w_fire;
  logic          w_push;

  assign w_valid       = (w_count != '0);
  assign w_pop         = w_valid && bus.id_ready;
  // a slot freed by this cycle's pop can be re-credited immediately
  assign w_credit_used = {1'b0, r_outst} + {1'b0, w_count} - (CW+1)'(w_pop);
  assign w_req         = rst_n && !bus.redirect && (w_credit_used < (CW+1)'(QDEPTH));
  assign w_fire        = w_req && bus.imem_gnt;
  assign w_push        = bus.imem_rvalid && (r_drop == '0) && !bus.redirect;
  assign w_push_entry  = {bus.imem_rdata, r_resp_pc};

  // fetch/response PCs plus outstanding and stale-response counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_outst    <= '0;
      r_drop     <= '0;
    end else if (bus.redirect) begin
      r_fetch_pc <= word_align(bus.redirect_pc);
      r_resp_pc  <= word_align(bus.redirect_pc);
      r_drop     <= r_outst - CW'(bus.imem_rvalid);
      r_outst    <= r_outst - CW'(bus.imem_rvalid);
    end else begin
      if (w_fire) r_fetch_pc <= r_fetch_pc + PC_STEP;
      if (w_push) r_resp_pc  <= r_resp_pc + PC_STEP;
      if (bus.imem_rvalid && (r_drop != '0)) r_drop <= r_drop - CW'(1);
      r_outst <= r_outst + CW'(w_fire) - CW'(bus.imem_rvalid);
    end
  end

  fetch_unit_queue #(
    .DEPTH    (QDEPTH),
    .RESET_PC (RESET_PC)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (bus.redirect),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_count      (w_count),
    .o_head       (w_head)
  );

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_fetch_pc;
  assign bus.id_valid    = w_valid;
  assign bus.id_instr    = w_valid ? w_head.instr : NOP_INSTR;
  assign bus.id_pc       = w_head.pc;
  assign bus.id_pc_plus4 = w_head.pc + PC_STEP;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of the fetch stage against an in-order memory model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // memory model state
  int          cyc = 0;
  int          last_due = 0;
  int          mdue;
  int          extra_lat = 0;
  bit          rand_mode = 1'b0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'hC3A5_0000;
  endfunction

  // memory: accept grants and retire responses at the clock edge
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      pend_addr.delete(); pend_due.delete(); cyc = 0; last_due = 0;
    end else begin
      if (bus.imem_rvalid && pend_addr.size() > 0) begin
        void'(pend_addr.pop_front()); void'(pend_due.pop_front());
      end
      if (bus.imem_req && bus.imem_gnt) begin
        mdue = cyc + 1 + (rand_mode ? int'($urandom_range(0, 3)) : extra_lat);
        if (mdue <= last_due) mdue = last_due + 1;
        pend_addr.push_back(bus.imem_addr); pend_due.push_back(mdue);
        last_due = mdue;
      end
      cyc++;
    end
  end

  // memory: drive grant and response away from the active edge
  initial begin
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus.imem_gnt = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        bus.imem_rvalid = 1'b1; bus.imem_rdata = instr_of(pend_addr[0]);
      end else begin
        bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  task automatic adv(input logic ready, input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    bus.id_ready = ready; bus.redirect = redir; bus.redirect_pc = rpc;
    #1;
  endtask

  // leaves the bench 1 time unit into cycle 0 after release
  task automatic do_reset(input logic ready);
    rst_n = 1'b0; rand_mode = 1'b0; extra_lat = 0;
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.id_ready = ready;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.id_ready = 1'b0;
    @(negedge clk); #1;
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", bus.imem_req); end
    total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.id_valid); end
    total++; if (bus.id_instr !== 32'h13) begin bad++; $display("FAIL rst_instr got=%h exp=00000013", bus.id_instr); end
    total++; if (bus.id_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=00000000", bus.id_pc); end
    total++; if (bus.id_pc_plus4 !== 32'h4) begin bad++; $display("FAIL rst_pc4 got=%h exp=00000004", bus.id_pc_plus4); end
    do_reset(1'b0);
    total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL c0_req got=%b exp=1", bus.imem_req); end
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL c0_addr got=%h exp=00000000", bus.imem_addr); end
    repeat (3) adv(1'b0, 1'b0, 32'h0);
    total++; if (bus.id_valid !== 1'b1) begin bad++; $display("FAIL pre_async_valid got=%b exp=1", bus.id_valid); end
    rst_n = 1'b0; #1;
    total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b exp=0", bus.id_valid); end
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL async_req got=%b exp=0", bus.imem_req); end
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) adv(1'b1, 1'b0, 32'h0);
      total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL str_req k=%0d got=%b exp=1", k, bus.imem_req); end
      total++; if (bus.imem_addr !== 32'(4 * k)) begin bad++; $display("FAIL str_addr k=%0d got=%h exp=%h", k, bus.imem_addr, 32'(4 * k)); end
      total++; if (bus.id_valid !== (k >= 2)) begin bad++; $display("FAIL str_valid k=%0d got=%b exp=%b", k, bus.id_valid, k >= 2); end
      if (k >= 2) begin
        total++; if (bus.id_pc !== 32'(4 * (k - 2))) begin bad++; $display("FAIL str_pc k=%0d got=%h exp=%h", k, bus.id_pc, 32'(4 * (k - 2))); end
        total++; if (bus.id_instr !== instr_of(32'(4 * (k - 2)))) begin bad++; $display("FAIL str_instr k=%0d got=%h exp=%h", k, bus.id_instr, instr_of(32'(4 * (k - 2)))); end
        total++; if (bus.id_pc_plus4 !== 32'(4 * (k - 1))) begin bad++; $display("FAIL str_pc4 k=%0d got=%h exp=%h", k, bus.id_pc_plus4, 32'(4 * (k - 1))); end
      end else begin
        total++; if (bus.id_instr !== 32'h13) begin bad++; $display("FAIL str_nop k=%0d got=%h exp=00000013", k, bus.id_instr); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b1);
    repeat (3) adv(1'b1, 1'b0, 32'h0);
    for (int k = 4; k <= 8; k++) begin
      adv(1'b0, 1'b0, 32'h0);
      total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL bp_req k=%0d got=%b exp=0", k, bus.imem_req); end
      total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h8) begin bad++; $display("FAIL bp_hold k=%0d got=%b/%h exp=1/00000008", k, bus.id_valid, bus.id_pc); end
    end
    adv(1'b1, 1'b0, 32'h0);
    total++; if (bus.id_pc !== 32'h8 || bus.id_instr !== instr_of(32'h8)) begin bad++; $display("FAIL bp_rel0 got=%h/%h exp=00000008", bus.id_pc, bus.id_instr); end
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin bad++; $display("FAIL bp_reissue got=%b/%h exp=1/00000010", bus.imem_req, bus.imem_addr); end
    adv(1'b1, 1'b0, 32'h0);
    total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'hC || bus.id_instr !== instr_of(32'hC)) begin bad++; $display("FAIL bp_rel1 got=%b/%h/%h exp pc=0000000c", bus.id_valid, bus.id_pc, bus.id_instr); end
    adv(1'b1, 1'b0, 32'h0);
    total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h10) begin bad++; $display("FAIL bp_rel2 got=%b/%h exp=1/00000010", bus.id_valid, bus.id_pc); end
  endtask

  task automatic test_redirect();
    bit seen = 1'b0;
    do_reset(1'b1);
    extra_lat = 2;
    adv(1'b1, 1'b0, 32'h0);
    adv(1'b1, 1'b1, 32'h103);
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rd_req got=%b exp=0", bus.imem_req); end
    adv(1'b1, 1'b0, 32'h0);
    total++; if (bus.imem_addr !== 32'h100) begin bad++; $display("FAIL rd_addr got=%h exp=00000100", bus.imem_addr); end
    for (int k = 0; k < 20 && !seen; k++) begin
      if (bus.id_valid) begin
        seen = 1'b1;
        total++; if (bus.id_pc !== 32'h100) begin bad++; $display("FAIL rd_pc got=%h exp=00000100", bus.id_pc); end
        total++; if (bus.id_pc_plus4 !== 32'h104) begin bad++; $display("FAIL rd_pc4 got=%h exp=00000104", bus.id_pc_plus4); end
        total++; if (bus.id_instr !== instr_of(32'h100)) begin bad++; $display("FAIL rd_instr got=%h exp=%h", bus.id_instr, instr_of(32'h100)); end
      end else adv(1'b1, 1'b0, 32'h0);
    end
    total++; if (!seen) begin bad++; $display("FAIL rd_timeout got=no id_valid exp=id_valid within 20 cycles"); end
    adv(1'b1, 1'b0, 32'h0);
    total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h104) begin bad++; $display("FAIL rd_next got=%b/%h exp=1/00000104", bus.id_valid, bus.id_pc); end
  endtask

  task automatic test_redirect_collision();
    do_reset(1'b1);
    repeat (2) adv(1'b1, 1'b0, 32'h0);
    adv(1'b1, 1'b1, 32'h200);
    total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h4) begin bad++; $display("FAIL col_pop got=%b/%h exp=1/00000004", bus.id_valid, bus.id_pc); end
    total++; if (bus.imem_rvalid !== 1'b1) begin bad++; $display("FAIL col_setup_rvalid got=%b exp=1", bus.imem_rvalid); end
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL col_req got=%b exp=0", bus.imem_req); end
    adv(1'b1, 1'b0, 32'h0);
    total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL col_empty got=%b exp=0", bus.id_valid); end
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin bad++; $display("FAIL col_issue got=%b/%h exp=1/00000200", bus.imem_req, bus.imem_addr); end
    adv(1'b1, 1'b0, 32'h0);
    total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL col_r2 got=%b exp=0", bus.id_valid); end
    adv(1'b1, 1'b0, 32'h0);
    total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h200 || bus.id_instr !== instr_of(32'h200)) begin bad++; $display("FAIL col_r3 got=%b/%h/%h exp pc=00000200", bus.id_valid, bus.id_pc, bus.id_instr); end
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFE; #1;
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL wr_req0 got=%b exp=0", bus.imem_req); end
    adv(1'b1, 1'b0, 32'h0);
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wr_top got=%b/%h exp=1/fffffffc", bus.imem_req, bus.imem_addr); end
    adv(1'b1, 1'b0, 32'h0);
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL wr_addr got=%h exp=00000000", bus.imem_addr); end
    adv(1'b1, 1'b0, 32'h0);
    total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wr_pc got=%b/%h exp=1/fffffffc", bus.id_valid, bus.id_pc); end
    total++; if (bus.id_pc_plus4 !== 32'h0) begin bad++; $display("FAIL wr_pc4 got=%h exp=00000000", bus.id_pc_plus4); end
    adv(1'b1, 1'b0, 32'h0);
    total++; if (bus.id_pc !== 32'h0 || bus.id_pc_plus4 !== 32'h4) begin bad++; $display("FAIL wr_next got=%h/%h exp=00000000/00000004", bus.id_pc, bus.id_pc_plus4); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] rpc;
    logic        rdy, rdr;
    int          delivered = 0;
    do_reset(1'b1);
    rand_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rdr = ($urandom_range(0, 39) == 0);
      rpc = $urandom & 32'h0000_FFFF;
      adv(rdy, rdr, rpc);
      if (bus.id_valid && bus.id_ready) begin
        delivered++;
        total++;
        if (bus.id_pc !== exp_pc || bus.id_instr !== instr_of(exp_pc)) begin
          bad++; $display("FAIL rnd_order n=%0d got=%h/%h exp=%h/%h", n, bus.id_pc, bus.id_instr, exp_pc, instr_of(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
      if (rdr) exp_pc = rpc & ~32'h3;
    end
    adv(1'b0, 1'b0, 32'h0);
    rand_mode = 1'b0;
    total++; if (delivered < 50) begin bad++; $display("FAIL rnd_progress got=%0d exp>=50", delivered); end
  endtask

  initial begin
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.id_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_collision();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
